// File: rtl/cache_axi_master.sv
// cache_axi_master
// Memory-side stage behind the cache core. Each cache line request becomes a
// single AXI4 INCR burst (one cache chunk per beat, BEATS beats per line),
// with one transaction in flight at a time and all IDs left at zero.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   addr_valid_in/addr_in/rw_in line request (rw_in=1 write-back, 0 fill)
//   req_ready                   request accepted when high with addr_valid_in
//   valid_wb/ready_wb/data_wb   write-back chunk stream from the cache
//   valid_ld/ready_ld/data_ld   fill chunk stream to the cache
//   xfer_done                   one-cycle pulse when a burst completes
//   bus_err                     sticky error (bad response or rlast misplacement)
//   aw*/w*/b*/ar*/r*            AXI4 master channels
module cache_axi_master #(
   parameter int ADDR_SIZE      = 32,
   parameter int DATA_SIZE      = 32,
   parameter int WR_M_DATA_SIZE = 4,
   parameter int BLOCK_SIZE     = 6,
   localparam int DW            = DATA_SIZE * WR_M_DATA_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 addr_valid_in,
   input  logic [ADDR_SIZE-1:0] addr_in,
   input  logic                 rw_in,
   output logic                 req_ready,
   input  logic                 valid_wb,
   output logic                 ready_wb,
   input  logic [DW-1:0]        data_wb,
   output logic                 valid_ld,
   input  logic                 ready_ld,
   output logic [DW-1:0]        data_ld,
   output logic                 xfer_done,
   output logic                 bus_err,
   output logic                 awvalid,
   input  logic                 awready,
   output logic [ADDR_SIZE-1:0] awaddr,
   output logic [7:0]           awlen,
   output logic [2:0]           awsize,
   output logic [1:0]           awburst,
   output logic                 wvalid,
   input  logic                 wready,
   output logic [DW-1:0]        wdata,
   output logic [DW/8-1:0]      wstrb,
   output logic                 wlast,
   input  logic                 bvalid,
   output logic                 bready,
   input  logic [1:0]           bresp,
   output logic                 arvalid,
   input  logic                 arready,
   output logic [ADDR_SIZE-1:0] araddr,
   output logic [7:0]           arlen,
   output logic [2:0]           arsize,
   output logic [1:0]           arburst,
   input  logic                 rvalid,
   output logic                 rready,
   input  logic [DW-1:0]        rdata,
   input  logic [1:0]           rresp,
   input  logic                 rlast
);

   localparam int BEATS  = (1 << BLOCK_SIZE) / (DW / 8);
   localparam int CW     = $clog2(BEATS) + 1;
   localparam int AXSIZE = $clog2(DW / 8);
   localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'((1 << BLOCK_SIZE) - 1);

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

   state_t               state, state_nx;
   logic [CW-1:0]        beat_cnt, cnt_nx;
   logic [ADDR_SIZE-1:0] line_addr, line_nx;
   logic                 err_q, err_nx;
   logic                 last_beat;

   assign last_beat = (beat_cnt == CW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         line_addr <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nx;
         beat_cnt  <= cnt_nx;
         line_addr <= line_nx;
         err_q     <= err_nx;
      end
   end

   // Outputs are decoded from the registered state and forced low while rst
   // is high, so an abandoned burst drops its valids in the reset cycle itself.
   always_comb begin
      state_nx  = state;
      cnt_nx    = beat_cnt;
      line_nx   = line_addr;
      err_nx    = err_q;
      req_ready = 1'b0;
      ready_wb  = 1'b0;
      valid_ld  = 1'b0;
      data_ld   = '0;
      xfer_done = 1'b0;
      bus_err   = 1'b0;
      awvalid   = 1'b0;
      awaddr    = '0;
      awlen     = '0;
      awsize    = '0;
      awburst   = '0;
      wvalid    = 1'b0;
      wdata     = '0;
      wstrb     = '0;
      wlast     = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      araddr    = '0;
      arlen     = '0;
      arsize    = '0;
      arburst   = '0;
      rready    = 1'b0;
      if (!rst) begin
         bus_err = err_q;
         unique case (state)
            IDLE: begin
               req_ready = 1'b1;
               if (addr_valid_in) begin
                  line_nx  = addr_in & LINE_MASK;
                  state_nx = rw_in ? AW : AR;
               end
            end
            AW: begin
               awvalid = 1'b1;
               awaddr  = line_addr;
               awlen   = 8'(BEATS - 1);
               awsize  = 3'(AXSIZE);
               awburst = 2'b01;
               if (awready) begin
                  state_nx = W;
                  cnt_nx   = '0;
               end
            end
            W: begin
               wvalid   = valid_wb;
               ready_wb = wready;
               wdata    = data_wb;
               wstrb    = '1;
               wlast    = last_beat;
               if (valid_wb && wready) begin
                  cnt_nx = beat_cnt + CW'(1);
                  if (last_beat) state_nx = B;
               end
            end
            B: begin
               bready = 1'b1;
               if (bvalid) begin
                  err_nx    = err_q | (bresp != 2'b00);
                  xfer_done = 1'b1;
                  state_nx  = IDLE;
               end
            end
            AR: begin
               arvalid = 1'b1;
               araddr  = line_addr;
               arlen   = 8'(BEATS - 1);
               arsize  = 3'(AXSIZE);
               arburst = 2'b01;
               if (arready) begin
                  state_nx = R;
                  cnt_nx   = '0;
               end
            end
            R: begin
               valid_ld = rvalid;
               rready   = ready_ld;
               data_ld  = rdata;
               if (rvalid && ready_ld) begin
                  // Burst length is counted locally; a misplaced rlast is
                  // flagged but never shortens or extends the burst.
                  err_nx = err_q | (rresp != 2'b00) | (rlast != last_beat);
                  cnt_nx = beat_cnt + CW'(1);
                  if (last_beat) begin
                     xfer_done = 1'b1;
                     state_nx  = IDLE;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_axi_master.sv
// tb_cache_axi_master
// Directed sequence with randomized data, addresses and handshake timing.
// The bench plays both the cache and the AXI slave; expected values come from
// a line-level model (masked address, chunk list, sticky error bit).
module tb_cache_axi_master;

   localparam int DW = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic            addr_valid_in, rw_in, req_ready;
   logic [31:0]     addr_in;
   logic            valid_wb, ready_wb, valid_ld, ready_ld;
   logic [DW-1:0]   data_wb, data_ld;
   logic            xfer_done, bus_err;
   logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0]     awaddr, araddr;
   logic [7:0]      awlen, arlen;
   logic [2:0]      awsize, arsize;
   logic [1:0]      awburst, arburst, bresp, rresp;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic            arvalid, arready, rvalid, rready, rlast;

   always #5 clk = ~clk;

   cache_axi_master #(.ADDR_SIZE(32), .DATA_SIZE(32), .WR_M_DATA_SIZE(4), .BLOCK_SIZE(6)) dut (
      .clk(clk), .rst(rst),
      .addr_valid_in(addr_valid_in), .addr_in(addr_in), .rw_in(rw_in), .req_ready(req_ready),
      .valid_wb(valid_wb), .ready_wb(ready_wb), .data_wb(data_wb),
      .valid_ld(valid_ld), .ready_ld(ready_ld), .data_ld(data_ld),
      .xfer_done(xfer_done), .bus_err(bus_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int aw_hs = 0, ar_hs = 0;
   bit model_err = 1'b0;
   logic [DW-1:0] chunks [4];

   always @(posedge clk) begin
      if (!rst && awvalid && awready) aw_hs <= aw_hs + 1;
      if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_slave();
      valid_wb = 1'b0; data_wb = '0; ready_ld = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
   endtask

   task automatic rand_chunks();
      for (int i = 0; i < 4; i++) chunks[i] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Presents a request in IDLE; also checks the state left by the previous burst.
   task automatic issue(input logic [31:0] a, input bit rw, input bit hold);
      @(negedge clk);
      idle_slave();
      addr_valid_in = 1'b1; addr_in = a; rw_in = rw;
      #1;
      chk("req_ready_idle", req_ready, 1);
      chk("bus_err_model", bus_err, model_err);
      chk("xfer_done_idle", xfer_done, 0);
      @(posedge clk); #1;
      if (!hold) addr_valid_in = 1'b0;
   endtask

   task automatic addr_phase(input logic [31:0] a, input int dly, input bit is_wr);
      logic [31:0] line;
      line = a & 32'hFFFF_FFC0;
      for (int c = 0; c <= dly; c++) begin
         @(negedge clk);
         if (is_wr) begin
            awready = (c == dly); valid_wb = 1'b1; data_wb = chunks[0]; wready = 1'b1;
         end else begin
            arready = (c == dly);
         end
         #1;
         chk("req_ready_busy", req_ready, 0);
         if (is_wr) begin
            chk("awvalid", awvalid, 1);
            chk("awaddr", awaddr, line);
            chk("awlen", awlen, 3);
            chk("awsize", awsize, 4);
            chk("awburst", awburst, 1);
            chk("wvalid_before_aw", wvalid, 0);
            chk("ready_wb_before_aw", ready_wb, 0);
            chk("arvalid_in_write", arvalid, 0);
         end else begin
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, line);
            chk("arlen", arlen, 3);
            chk("arsize", arsize, 4);
            chk("arburst", arburst, 1);
            chk("awvalid_in_read", awvalid, 0);
            chk("valid_ld_before_ar", valid_ld, 0);
         end
      end
   endtask

   task automatic w_phase(input bit rnd);
      int idx = 0, cyc = 0;
      bit hs_prev = 1'b0;
      while (idx < 4 && cyc < 64) begin
         @(negedge clk);
         awready = 1'b0;
         if (hs_prev) valid_wb = 1'b0;
         if (!valid_wb) valid_wb = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         data_wb = chunks[idx];
         wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         chk("wvalid", wvalid, valid_wb);
         chk("ready_wb", ready_wb, wready);
         chk("wdata", wdata, chunks[idx]);
         chk("wlast", wlast, idx == 3);
         chk("wstrb", wstrb, 16'hFFFF);
         chk("awvalid_in_w", awvalid, 0);
         chk("xfer_done_in_w", xfer_done, 0);
         hs_prev = valid_wb && wready;
         if (hs_prev) idx++;
         cyc++;
      end
      chk("w_beat_count", idx, 4);
   endtask

   task automatic b_phase(input int dly, input logic [1:0] resp);
      for (int c = 0; c <= dly; c++) begin
         @(negedge clk);
         valid_wb = 1'b0; wready = 1'b0;
         bvalid = (c == dly); bresp = (c == dly) ? resp : 2'b00;
         #1;
         chk("bready", bready, 1);
         chk("wvalid_in_b", wvalid, 0);
         chk("req_ready_in_b", req_ready, 0);
         chk("xfer_done_b", xfer_done, c == dly);
      end
      model_err = model_err | (resp != 2'b00);
   endtask

   // mode 0: ready_ld always high, 1: ready_ld toggles 1,0,1,0..., 2: random
   task automatic r_phase(input int mode, input int err_beat, input int rlast_beat);
      int idx = 0, cyc = 0;
      bit hs = 1'b0, hs_prev = 1'b0;
      while (idx < 4 && cyc < 64) begin
         @(negedge clk);
         arready = 1'b0;
         if (hs_prev) rvalid = 1'b0;
         if (!rvalid) rvalid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         rdata = chunks[idx];
         rresp = (idx == err_beat) ? 2'b10 : 2'b00;
         rlast = (idx == rlast_beat);
         ready_ld = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         #1;
         hs = rvalid && ready_ld;
         chk("valid_ld", valid_ld, rvalid);
         chk("rready", rready, ready_ld);
         chk("data_ld", data_ld, chunks[idx]);
         chk("xfer_done_r", xfer_done, hs && idx == 3);
         chk("arvalid_in_r", arvalid, 0);
         chk("req_ready_in_r", req_ready, 0);
         if (hs) begin
            model_err = model_err | (rresp != 2'b00) | (rlast != (idx == 3));
            idx++;
         end
         hs_prev = hs;
         cyc++;
      end
      chk("r_beat_count", idx, 4);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1; addr_valid_in = 1'b0; idle_slave();
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_valid_ld", valid_ld, 0);
      chk("rst_xfer_done", xfer_done, 0);
      chk("rst_bus_err", bus_err, 0);
      @(negedge clk);
      rst = 1'b0;
      model_err = 1'b0;
   endtask

   initial begin
      logic [31:0] a, ra;
      int a0, r0;
      rst = 1'b1; addr_valid_in = 1'b0; addr_in = '0; rw_in = 1'b0;
      idle_slave();
      pulse_reset();

      // Directed write-back, no stalls
      for (int i = 0; i < 4; i++) chunks[i] = DW'(8'hA0 + i);
      issue(32'h0000_12F4, 1'b1, 1'b0);
      addr_phase(32'h0000_12F4, 0, 1'b1);
      w_phase(1'b0);
      b_phase(0, 2'b00);

      // Line fill with ready_ld toggling
      for (int i = 0; i < 4; i++) chunks[i] = DW'(8'h10 + i);
      issue(32'h8000_0040, 1'b0, 1'b0);
      addr_phase(32'h8000_0040, 0, 1'b0);
      r_phase(1, -1, 3);

      // Delayed address and response channel
      rand_chunks();
      a = $urandom;
      issue(a, 1'b1, 1'b0);
      addr_phase(a, 5, 1'b1);
      w_phase(1'b0);
      b_phase(3, 2'b00);

      // Randomized clean transfers
      for (int k = 0; k < 8; k++) begin
         rand_chunks();
         a = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            issue(a, 1'b1, 1'b0);
            addr_phase(a, $urandom_range(0, 3), 1'b1);
            w_phase(1'b1);
            b_phase($urandom_range(0, 3), 2'b00);
         end else begin
            issue(a, 1'b0, 1'b0);
            addr_phase(a, $urandom_range(0, 3), 1'b0);
            r_phase(2, -1, 3);
         end
      end

      // SLVERR on read beat 1, then a clean write: bus_err must stay set
      rand_chunks();
      a = $urandom;
      issue(a, 1'b0, 1'b0);
      addr_phase(a, 1, 1'b0);
      r_phase(0, 1, 3);
      rand_chunks();
      issue(a ^ 32'h0000_1000, 1'b1, 1'b0);
      addr_phase(a ^ 32'h0000_1000, 0, 1'b1);
      w_phase(1'b1);
      b_phase(1, 2'b00);
      issue(a, 1'b0, 1'b0);
      addr_phase(a, 0, 1'b0);
      r_phase(2, -1, 3);

      // Early rlast on beat 2 after a reset: flagged, burst still runs 4 beats
      pulse_reset();
      rand_chunks();
      a = $urandom;
      issue(a, 1'b0, 1'b0);
      addr_phase(a, 0, 1'b0);
      r_phase(0, -1, 2);

      // Reset in the middle of a write burst
      pulse_reset();
      rand_chunks();
      a = $urandom;
      issue(a, 1'b1, 1'b0);
      addr_phase(a, 0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         awready = 1'b0; valid_wb = 1'b1; wready = 1'b1; data_wb = chunks[i];
         #1;
         chk("mid_wvalid", wvalid, 1);
         chk("mid_wdata", wdata, chunks[i]);
      end
      @(negedge clk);
      rst = 1'b1; data_wb = chunks[2];
      #1;
      chk("rst_mid_wvalid", wvalid, 0);
      chk("rst_mid_ready_wb", ready_wb, 0);
      chk("rst_mid_awvalid", awvalid, 0);
      @(negedge clk);
      rst = 1'b0; idle_slave(); model_err = 1'b0;
      #1;
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_wvalid", wvalid, 0);
      chk("post_rst_awvalid", awvalid, 0);
      rand_chunks();
      a = $urandom;
      issue(a, 1'b0, 1'b0);
      addr_phase(a, 2, 1'b0);
      r_phase(2, -1, 3);

      // Back-to-back: read request held high during the write
      a0 = aw_hs; r0 = ar_hs;
      a = $urandom; ra = $urandom;
      rand_chunks();
      issue(a, 1'b1, 1'b1);
      addr_in = ra; rw_in = 1'b0;
      addr_phase(a, 1, 1'b1);
      w_phase(1'b1);
      b_phase(2, 2'b00);
      rand_chunks();
      issue(ra, 1'b0, 1'b0);
      addr_phase(ra, 0, 1'b0);
      r_phase(0, -1, 3);
      @(negedge clk);
      idle_slave();
      #1;
      chk("final_req_ready", req_ready, 1);
      chk("final_bus_err", bus_err, model_err);
      chk("b2b_aw_count", aw_hs - a0, 1);
      chk("b2b_ar_count", ar_hs - r0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cache_axi_master.md
Name: cache_axi_master

Overview:
- Memory-side stage directly downstream of the cache core.
- Converts the cache's line-request interface, write-back chunk stream and load chunk stream into AXI4 INCR burst transactions.
- Each line transfer is one AXI burst: one cache chunk per data beat, BEATS beats per line.
- Single outstanding transaction; IDs are not used (all zero at the interconnect).

Parameters:
- ADDR_SIZE, 32, address width.
- DATA_SIZE, 32, cache word width.
- WR_M_DATA_SIZE, 4, words per chunk; AXI data width DW = DATA_SIZE*WR_M_DATA_SIZE (128).
- BLOCK_SIZE, 6, log2 of line bytes.
- BEATS, (1<<BLOCK_SIZE)/(DW/8) = 4, derived; beats per line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr_valid_in  in  1  cache line request valid (level, held until accepted)
- addr_in  in  ADDR_SIZE  request address
- rw_in  in  1  1 = write-back, 0 = line fill
- req_ready  out  1  request accepted this cycle when high with addr_valid_in
- valid_wb  in  1  write-back chunk valid
- ready_wb  out  1  write-back chunk accepted
- data_wb  in  DW  write-back chunk; word i at [i*DATA_SIZE +: DATA_SIZE]
- valid_ld  out  1  fill chunk valid
- ready_ld  in  1  cache ready for fill chunk
- data_ld  out  DW  fill chunk, same packing
- xfer_done  out  1  one-cycle pulse at burst completion
- bus_err  out  1  sticky error flag
- awvalid/awready/awaddr[ADDR_SIZE]/awlen[8]/awsize[3]/awburst[2]: AXI AW channel (out/in/out/out/out/out)
- wvalid/wready/wdata[DW]/wstrb[DW/8]/wlast: AXI W channel (out/in/out/out/out)
- bvalid/bready/bresp[2]: AXI B channel (in/out/in)
- arvalid/arready/araddr/arlen/arsize/arburst: AXI AR channel (out/in/out/out/out/out)
- rvalid/rready/rdata[DW]/rresp[2]/rlast: AXI R channel (in/out/in/in/in)

Behaviour:
- Reset (synchronous, rst=1): state IDLE, beat_cnt 0, bus_err 0. All outputs are 0 except req_ready, which is 0 during reset and 1 in IDLE after reset.
- States: IDLE, AW, W, B, AR, R.
- IDLE: req_ready=1. On addr_valid_in:
  - Latch addr_in with the low BLOCK_SIZE bits forced to 0.
  - Go to AW if rw_in=1, else AR.
- AW: awvalid=1 (registered), awaddr = latched line address.
  - awlen=BEATS-1, awsize=log2(DW/8), awburst=2'b01.
  - Hold all AW values stable until awready. On awready go to W, beat_cnt=0.
- W: wvalid=valid_wb, ready_wb=wready, wdata=data_wb (combinational pass-through).
  - wstrb all ones; wlast=(beat_cnt==BEATS-1).
  - On each valid_wb&wready, beat_cnt++. On the last beat go to B.
- B: bready=1. On bvalid:
  - bus_err |= (bresp!=2'b00).
  - Pulse xfer_done, go to IDLE.
- AR: same as AW with the ar* signals. On arready go to R, beat_cnt=0.
- R: valid_ld=rvalid, rready=ready_ld, data_ld=rdata (pass-through).
  - On each handshake: bus_err |= (rresp!=0).
  - Also bus_err |= (rlast != (beat_cnt==BEATS-1)).
  - beat_cnt++.
  - The burst ends on the BEATS-th handshake, regardless of rlast. Then pulse xfer_done and go to IDLE.
- Outside the W state, ready_wb=0 and wvalid=0. Outside the R state, valid_ld=0 and rready=0.
- AXI handshake rules: valid never drops before its ready. Payload stays stable while valid&~ready.
- Minimum latency: request accept to AW/AR valid is 1 cycle.
  - Write burst to xfer_done: ≥ BEATS+3 cycles.
  - Read burst to xfer_done: ≥ BEATS+2 cycles.
- Back-to-back requests: the next request can be accepted the cycle after xfer_done.
- No request is accepted outside IDLE. addr_valid_in held high is accepted only once per IDLE visit.
- bus_err clears only on rst.
- Reset mid-burst: returns to IDLE next cycle and drops all valids immediately. The abandoned AXI transaction is not completed; the bench must reset the slave too.
- beat_cnt width: $clog2(BEATS)+1; it never wraps within a burst.

Test Plan:
- Write-back: rw_in=1, addr_in=0x0000_12F4, awready immediate, wready always 1, data chunks 0xA0..0xA3 → awaddr=0x0000_12C0, awlen=3, awsize=4, awburst=1. Four W beats carry 0xA0..0xA3 in order; wlast only on beat 3. bresp=0 → xfer_done pulse, bus_err=0.
- Read fill with backpressure: rw_in=0, addr 0x8000_0040; ready_ld toggles 1,0,1,0; rdata 0x10..0x13; rlast on 4th beat → araddr=0x8000_0040. Cache receives 0x10..0x13 with no duplicates or drops. rready mirrors ready_ld. xfer_done after the 4th handshake.
- Delayed address/response: awready low 5 cycles, bvalid delayed 3 cycles → awvalid and awaddr held stable all 5 cycles. No W beat before AW is accepted. req_ready stays 0 until IDLE.
- Error flags: rresp=2'b10 on beat 1 → bus_err=1 and stays 1 through the next clean transfer. Separately, rlast asserted on beat 2 → bus_err=1 and the burst still completes after 4 beats.
- Reset mid-burst: assert rst after 2 W beats → next cycle wvalid=0, awvalid=0, req_ready=1. A new read request then completes normally.
- Back-to-back: write then read held on addr_valid_in → read AR issued only after the write's xfer_done. Exactly one AW and one AR.
